// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the single-cycle core.
// Holds the PC, performs one request/response fetch per instruction, presents
// the captured word on inst, and redirects the PC on consume (sequential,
// branch/JAL, JALR). Misaligned targets latch a sticky trap; a retired
// instruction counter advances on every successful consume.
`timescale 1ns/1ps

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic [1:0]  pc_src,
    input  logic [31:0] inmExt,
    input  logic [31:0] alu_result,
    output logic        misaligned,
    output logic [31:0] inst_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_TRAP  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_count_q, inst_count_d;
    logic        misaligned_q, misaligned_d;
    logic        imem_req_q, imem_req_d;
    logic        inst_valid_q, inst_valid_d;

    logic [31:0] pc_plus4_s;
    logic [31:0] next_pc_s;

    // Word alignment test used for every redirect target.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    // JALR target: the ALU result with bit 0 forced low, so only bit 1 can fault.
    function automatic logic [31:0] jalr_target(input logic [31:0] addr);
        return {addr[31:1], 1'b0};
    endfunction

    assign pc_plus4_s = pc_q + 32'd4;

    // Select the candidate next PC from the redirect source.
    always_comb begin
        next_pc_s = pc_plus4_s;
        case (pc_src)
            2'b00:   next_pc_s = pc_plus4_s;
            2'b01:   next_pc_s = pc_q + inmExt;
            2'b10:   next_pc_s = jalr_target(alu_result);
            default: next_pc_s = pc_plus4_s;
        endcase
    end

    // Fetch sequencing: next state, PC, instruction, counter and trap flag.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_count_d = inst_count_q;
        misaligned_d = misaligned_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    inst_d  = imem_rdata;
                    state_d = ST_VALID;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_VALID: begin
                if (stall) begin
                    state_d = ST_VALID;
                end else if (!is_word_aligned(next_pc_s)) begin
                    // pc stays on the faulting instruction; count is not bumped
                    inst_d       = NOP_INST;
                    misaligned_d = 1'b1;
                    state_d      = ST_TRAP;
                end else begin
                    inst_d       = NOP_INST;
                    pc_d         = next_pc_s;
                    inst_count_d = inst_count_q + 32'd1;
                    state_d      = ST_FETCH;
                end
            end
            ST_TRAP: begin
                misaligned_d = 1'b1;
                state_d      = ST_TRAP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        imem_req_d   = (state_d == ST_FETCH);
        inst_valid_d = (state_d == ST_VALID);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            inst_count_q <= 32'd0;
            misaligned_q <= 1'b0;
            imem_req_q   <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_count_q <= inst_count_d;
            misaligned_q <= misaligned_d;
            imem_req_q   <= imem_req_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign pc         = pc_q;
    assign pc_plus4   = pc_plus4_s;
    assign misaligned = misaligned_q;
    assign inst_count = inst_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. A driver consumes
// instructions with random redirects, a memory responder serves fetches with
// configurable wait states, and a monitor pops expected (pc, inst, count) or
// trap records whenever inst_valid or misaligned rises.
`timescale 1ns/1ps

module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        stall = 1'b1;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] inmExt = 32'd0;
    logic [31:0] alu_result = 32'd0;
    logic        misaligned;
    logic [31:0] inst_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid),
        .pc(pc), .pc_plus4(pc_plus4),
        .stall(stall), .pc_src(pc_src),
        .inmExt(inmExt), .alu_result(alu_result),
        .misaligned(misaligned), .inst_count(inst_count)
    );

    typedef struct packed {
        logic        trap;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] preset_mem [logic [31:0]];

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_trapped;

    // memory responder control: wait_cfg < 0 picks 0..3 wait cycles at random
    int wait_cfg = 0;
    bit in_fetch = 1'b0;
    int wait_left = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (preset_mem.exists(a)) return preset_mem[a];
        return {a[7:0], a[31:24] ^ 8'h5A, a[23:16], a[15:8] ^ 8'h3C};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, req, $time);
        end
    endtask

    // Instruction memory: serves the requested word after the configured wait,
    // and drives noise on the response lines outside a fetch.
    always @(negedge clk) begin
        if (imem_req) begin
            if (!in_fetch) begin
                in_fetch  = 1'b1;
                wait_left = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
            end
            if (wait_left == 0) begin
                imem_ready = 1'b1;
                imem_rdata = mem_word(imem_addr);
                in_fetch   = 1'b0;
            end else begin
                imem_ready = 1'b0;
                imem_rdata = $urandom;
                wait_left--;
            end
        end else begin
            imem_ready = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
        end
        if (rst) in_fetch = 1'b0;
    end

    // Monitor: pop and compare one expectation per presented instruction or trap.
    bit prev_valid = 1'b0;
    bit prev_mis = 1'b0;
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (inst_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL sb_underflow: inst_valid rose at pc %h with nothing expected", pc);
            end else begin
                e = exp_q.pop_front();
                check1("sb_kind_valid", e.trap, 1'b0);
                check("sb_pc", pc, e.pc);
                check("sb_inst", inst, e.inst);
                check("sb_count", inst_count, e.cnt);
            end
        end
        if (misaligned && !prev_mis) begin
            if (exp_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL sb_underflow: misaligned rose at pc %h with nothing expected", pc);
            end else begin
                e = exp_q.pop_front();
                check1("sb_kind_trap", e.trap, 1'b1);
                check("sb_trap_pc", pc, e.pc);
                check("sb_trap_count", inst_count, e.cnt);
            end
        end
        prev_valid = inst_valid;
        prev_mis   = misaligned;
        check("imem_addr_eq_pc", imem_addr, pc);
        check("pc_plus4", pc_plus4, pc + 32'd4);
    end

    // Apply reset (optionally starting on the current negedge) and check the
    // reset state and first-request timing.
    task automatic do_reset(input bit now);
        if (!now) @(negedge clk);
        rst   = 1'b1;
        stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        check("rst_inst", inst, NOP_INST);
        check1("rst_inst_valid", inst_valid, 1'b0);
        check1("rst_imem_req", imem_req, 1'b0);
        check1("rst_misaligned", misaligned, 1'b0);
        check("rst_count", inst_count, 32'd0);
        check("rst_pc", pc, RESET_PC);
        m_pc      = RESET_PC;
        m_cnt     = 32'd0;
        m_trapped = 1'b0;
        exp_q.push_back('{trap: 1'b0, pc: RESET_PC, inst: mem_word(RESET_PC), cnt: 32'd0});
        rst = 1'b0;
        @(negedge clk);
        check1("first_req_cycle2", imem_req, 1'b1);
    endtask

    // Wait (bounded) for inst_valid, counting request cycles and checking the
    // fetch holds pc and shows the NOP word meanwhile.
    task automatic wait_valid(output int req_cycles);
        logic [31:0] pc0;
        req_cycles = 0;
        pc0 = pc;
        for (int i = 0; i < 64 && !inst_valid; i++) begin
            if (imem_req) req_cycles++;
            check("fetch_pc_hold", pc, pc0);
            check("fetch_inst_nop", inst, NOP_INST);
            @(negedge clk);
        end
        if (!inst_valid) begin
            vectors++; miscompares++;
            $display("FAIL valid_timeout: inst_valid still %b after 64 cycles at pc %h", inst_valid, pc);
        end
    endtask

    // Hold VALID for nstall cycles, then consume with the given redirect and
    // check the cycle after the consume edge against the model.
    task automatic consume(input logic [1:0] src, input logic [31:0] imm,
                           input logic [31:0] alu, input int nstall);
        logic [31:0] i0, p0, tgt;
        i0 = inst;
        p0 = pc;
        for (int k = 0; k < nstall; k++) begin
            stall = 1'b1;
            @(negedge clk);
            check("stall_inst", inst, i0);
            check("stall_pc", pc, p0);
            check1("stall_valid", inst_valid, 1'b1);
        end
        stall      = 1'b0;
        pc_src     = src;
        inmExt     = imm;
        alu_result = alu;
        if (src == 2'b01)      tgt = m_pc + imm;
        else if (src == 2'b10) tgt = (alu >> 1) << 1;
        else                   tgt = m_pc + 32'd4;
        if (tgt % 4 != 0) begin
            m_trapped = 1'b1;
            exp_q.push_back('{trap: 1'b1, pc: m_pc, inst: NOP_INST, cnt: m_cnt});
        end else begin
            m_pc  = tgt;
            m_cnt = m_cnt + 32'd1;
            exp_q.push_back('{trap: 1'b0, pc: m_pc, inst: mem_word(m_pc), cnt: m_cnt});
        end
        @(negedge clk);
        stall      = 1'b1;
        pc_src     = 2'($urandom_range(0, 3));
        inmExt     = $urandom;
        alu_result = $urandom;
        if (m_trapped) begin
            check1("trap_flag", misaligned, 1'b1);
            check1("trap_req", imem_req, 1'b0);
            check1("trap_valid", inst_valid, 1'b0);
            check("trap_pc_kept", pc, p0);
            check("trap_count", inst_count, m_cnt);
        end else begin
            check("redirect_pc", pc, m_pc);
            check("redirect_addr", imem_addr, m_pc);
            check1("redirect_req", imem_req, 1'b1);
            check1("redirect_valid", inst_valid, 1'b0);
            check("consume_count", inst_count, m_cnt);
        end
    endtask

    task automatic trap_hold(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            check1("trap_sticky", misaligned, 1'b1);
            check1("trap_no_req", imem_req, 1'b0);
            check1("trap_no_valid", inst_valid, 1'b0);
            check("trap_pc_stable", pc, m_pc);
        end
    endtask

    // Directed scenarios followed by a randomized run.
    initial begin
        int rc;
        logic [1:0]  r_src;
        logic [31:0] r_imm, r_alu;
        preset_mem[32'h0000_0000] = 32'h0050_0093;
        preset_mem[32'h0000_0004] = 32'h0010_8113;
        wait_cfg = 0;

        // reset and straight-line fetch
        do_reset(1'b1);
        wait_valid(rc);
        check("first_fetch_req_cycles", 32'(rc), 32'd1);
        check("line_inst0", inst, 32'h0050_0093);
        check("line_pc0", pc, 32'h0000_0000);
        consume(2'b00, 32'd0, 32'd0, 0);
        wait_valid(rc);
        check("line_inst1", inst, 32'h0010_8113);
        check("line_pc1", pc, 32'h0000_0004);
        wait_cfg = 3;
        consume(2'b00, 32'd0, 32'd0, 0);
        check("line_count2", inst_count, 32'd2);

        // three wait states, then a two-cycle stall
        wait_valid(rc);
        check("wait_req_cycles", 32'(rc), 32'd4);
        wait_cfg = 0;
        consume(2'b00, 32'd0, 32'd0, 2);
        check("stall_then_pc", pc, 32'h0000_000C);

        // branch / JAL redirects from 0x100
        wait_valid(rc);
        consume(2'b10, 32'd0, 32'h0000_0100, 0);
        wait_valid(rc);
        consume(2'b01, 32'hFFFF_FFF8, 32'd0, 0);
        check("branch_back_addr", imem_addr, 32'h0000_00F8);
        wait_valid(rc);
        consume(2'b10, 32'd0, 32'h0000_0100, 1);
        wait_valid(rc);
        consume(2'b01, 32'h0000_0010, 32'd0, 0);
        check("branch_fwd_addr", imem_addr, 32'h0000_0110);

        // JALR: bit 0 cleared, then a bit-1 fault
        wait_valid(rc);
        consume(2'b10, 32'd0, 32'h0000_0201, 0);
        check("jalr_pc", pc, 32'h0000_0200);
        check1("jalr_no_trap", misaligned, 1'b0);
        wait_valid(rc);
        consume(2'b10, 32'd0, 32'h0000_0202, 0);
        check("jalr_trap_pc", pc, 32'h0000_0200);
        trap_hold(4);

        // branch misalign, then reset clears the trap
        do_reset(1'b0);
        wait_valid(rc);
        consume(2'b10, 32'd0, 32'h0000_0100, 0);
        wait_valid(rc);
        consume(2'b01, 32'h0000_0006, 32'd0, 0);
        check1("branch_trap", misaligned, 1'b1);
        check("branch_trap_pc", pc, 32'h0000_0100);
        trap_hold(2);
        do_reset(1'b0);

        // reset in FETCH while the memory answers
        wait_valid(rc);
        consume(2'b00, 32'd0, 32'd0, 0);
        check1("midfetch_req", imem_req, 1'b1);
        do_reset(1'b1);
        wait_valid(rc);
        check("midfetch_restart_inst", inst, 32'h0050_0093);

        // pc wrap from 0xFFFF_FFFC
        consume(2'b10, 32'd0, 32'hFFFF_FFFC, 0);
        wait_valid(rc);
        check("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
        consume(2'b00, 32'd0, 32'd0, 0);
        check("wrap_pc", pc, 32'h0000_0000);
        check1("wrap_no_trap", misaligned, 1'b0);

        // counter wrap with the count forced to all ones
        wait_valid(rc);
        force dut.inst_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.inst_count_q;
        m_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        check("count_preload", inst_count, 32'hFFFF_FFFF);
        consume(2'b00, 32'd0, 32'd0, 0);
        check("count_wrap", inst_count, 32'd0);

        // randomized run
        wait_cfg = -1;
        for (int n = 0; n < 300; n++) begin
            wait_valid(rc);
            r_src = 2'($urandom_range(0, 3));
            r_imm = ($urandom_range(0, 7) == 0) ? 32'($urandom)
                                                : ((32'($urandom_range(0, 511)) - 32'd256) << 2);
            r_alu = ($urandom_range(0, 5) == 0) ? 32'($urandom)
                                                : ((32'($urandom) & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1)));
            consume(r_src, r_imm, r_alu, int'($urandom_range(0, 2)));
            if (m_trapped) begin
                trap_hold(2);
                do_reset(1'b0);
            end else if ($urandom_range(0, 39) == 0) begin
                do_reset(1'b1);
            end
        end
        wait_valid(rc);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

endmodule
